// File: rtl/sdith_pkg.sv
// Shared SDitH parameters: per-set selection, hypercube size, hash lengths, FSM state type.
`ifndef SDITH_CLOG2_DEFINED
`define SDITH_CLOG2_DEFINED
`define CLOG2(x) $clog2(x)
`endif

package sdith_pkg;

    // Each i_star index is one raw byte, so exactly 256 parties.
    localparam int unsigned D_HYPERCUBE = 8;

    function automatic int unsigned sel_lambda(input string ps);
        if (ps == "L3") return 192;
        if (ps == "L5") return 256;
        return 128;
    endfunction

    function automatic int unsigned sel_tau(input string ps);
        if (ps == "L3") return 26;
        if (ps == "L5") return 34;
        return 17;
    endfunction

    function automatic int unsigned sel_k(input string ps);
        if (ps == "L3") return 193;
        if (ps == "L5") return 278;
        return 126;
    endfunction

    function automatic int unsigned sel_t(input string ps);
        if (ps == "L5") return 4;
        return 3;
    endfunction

    function automatic int unsigned sel_d_split(input string ps);
        if (ps == "L1") return 1;
        return 2;
    endfunction

    // Absorb h2 (2*LAMBDA bits), squeeze one byte per repetition.
    function automatic int unsigned hash_input_bits(input int unsigned lambda);
        return 2 * lambda;
    endfunction

    function automatic int unsigned hash_output_bits(input int unsigned tau);
        return tau * 8;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSqueeze,
        StForce,
        StDone
    } evc_state_e;

endpackage

// File: rtl/sdith_word_ram.sv
// Single-port word RAM: synchronous write, combinational read; the caller registers the read data.
module sdith_word_ram #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32,
    localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Storage is never reset; contents survive a module reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sdith_expand_view_challenge.sv
// Expands h2 through the external XOF into TAU byte-wide hidden-party indices i_star.
module sdith_expand_view_challenge
    import sdith_pkg::*;
#(
    parameter string       PARAMETER_SET = "L1",
    parameter int unsigned LAMBDA        = sel_lambda(PARAMETER_SET),
    parameter int unsigned SEED_SIZE     = LAMBDA,
    parameter int unsigned TAU           = sel_tau(PARAMETER_SET),
    parameter int unsigned H2_WORDS      = 2 * SEED_SIZE / 32,
    localparam int unsigned AW = $clog2(H2_WORDS),
    localparam int unsigned IW = $clog2(TAU)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_done,
    input  logic          i_h2_wr_en,
    input  logic          i_h2_rd_en,
    input  logic [AW-1:0] i_h2_addr,
    input  logic [31:0]   i_h2,
    output logic [31:0]   o_h2,
    input  logic          i_i_star_rd_en,
    input  logic [IW-1:0] i_i_star_addr,
    output logic [7:0]    o_i_star,
    output logic [31:0]   o_hash_data_in,
    input  logic [AW-1:0] i_hash_addr,
    input  logic          i_hash_rd_en,
    input  logic [31:0]   i_hash_data_out,
    input  logic          i_hash_data_out_valid,
    output logic          o_hash_data_out_ready,
    output logic [31:0]   o_hash_input_length,
    output logic [31:0]   o_hash_output_length,
    output logic          o_hash_start,
    input  logic          i_hash_force_done_ack,
    output logic          o_hash_force_done
);

    // Counter must reach TAU+3 (last partial word pushes past TAU).
    localparam int unsigned CW = $clog2(TAU + 4);

    if (D_HYPERCUBE != 8) begin : g_bad_d_hypercube
        $error("sdith_expand_view_challenge supports only D_HYPERCUBE == 8");
    end

    evc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    i_star_q [TAU];

    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;
    logic          hash_rd, host_rd;
    logic          accept;

    assign o_hash_input_length  = 32'(hash_input_bits(LAMBDA));
    assign o_hash_output_length = 32'(hash_output_bits(TAU));

    // Port arbitration: host write, then XOF read, then host read.
    assign hash_rd = i_hash_rd_en && !i_h2_wr_en;
    assign host_rd = i_h2_rd_en && !i_h2_wr_en && !i_hash_rd_en;
    assign ram_addr = hash_rd ? i_hash_addr : i_h2_addr;

    sdith_word_ram #(
        .Depth (H2_WORDS),
        .Width (32)
    ) u_h2_ram (
        .clk_i   (i_clk),
        .we_i    (i_h2_wr_en),
        .addr_i  (ram_addr),
        .wdata_i (i_h2),
        .rdata_o (ram_rdata)
    );

    assign accept = (state_q == StSqueeze) && i_hash_data_out_valid;

    // Next-state logic and control outputs, decoded from the current state.
    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        o_hash_start          = 1'b0;
        o_hash_data_out_ready = 1'b0;
        o_hash_force_done     = 1'b0;
        o_done                = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StStart;
            end
            StStart: begin
                o_hash_start = 1'b1;
                cnt_d        = '0;
                state_d      = StSqueeze;
            end
            StSqueeze: begin
                o_hash_data_out_ready = 1'b1;
                if (i_hash_data_out_valid) begin
                    cnt_d = cnt_q + CW'(4);
                    if (int'(cnt_d) >= int'(TAU)) state_d = StForce;
                end
            end
            StForce: begin
                o_hash_force_done = 1'b1;
                if (i_hash_force_done_ack) state_d = StDone;
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and registered read ports.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            o_h2           <= '0;
            o_hash_data_in <= '0;
            o_i_star       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hash_rd) o_hash_data_in <= ram_rdata;
            if (host_rd) o_h2 <= ram_rdata;
            if (i_i_star_rd_en) o_i_star <= i_star_q[i_i_star_addr];
        end
    end

    // Scatter the little-endian bytes of each accepted word into i_star[cnt..cnt+3], clipped at TAU.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < int'(TAU); k++) begin
                for (int j = 0; j < 4; j++) begin
                    if (int'(cnt_q) + j == k) i_star_q[k] <= i_hash_data_out[8*j +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdith_expand_view_challenge.sv
// Directed bench for sdith_expand_view_challenge with a behavioural mock XOF.
module tb_sdith_expand_view_challenge;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        o_done;
    logic        i_h2_wr_en = 1'b0;
    logic        i_h2_rd_en = 1'b0;
    logic [2:0]  i_h2_addr = '0;
    logic [31:0] i_h2 = '0;
    logic [31:0] o_h2;
    logic        i_i_star_rd_en = 1'b0;
    logic [4:0]  i_i_star_addr = '0;
    logic [7:0]  o_i_star;
    logic [31:0] o_hash_data_in;
    logic [2:0]  i_hash_addr = '0;
    logic        i_hash_rd_en = 1'b0;
    logic [31:0] i_hash_data_out = '0;
    logic        i_hash_data_out_valid = 1'b0;
    logic        o_hash_data_out_ready;
    logic [31:0] o_hash_input_length;
    logic [31:0] o_hash_output_length;
    logic        o_hash_start;
    logic        i_hash_force_done_ack = 1'b0;
    logic        o_hash_force_done;

    always #5 clk = ~clk;

    sdith_expand_view_challenge dut (
        .i_clk                 (clk),
        .i_rst                 (i_rst),
        .i_start               (i_start),
        .o_done                (o_done),
        .i_h2_wr_en            (i_h2_wr_en),
        .i_h2_rd_en            (i_h2_rd_en),
        .i_h2_addr             (i_h2_addr),
        .i_h2                  (i_h2),
        .o_h2                  (o_h2),
        .i_i_star_rd_en        (i_i_star_rd_en),
        .i_i_star_addr         (i_i_star_addr),
        .o_i_star              (o_i_star),
        .o_hash_data_in        (o_hash_data_in),
        .i_hash_addr           (i_hash_addr),
        .i_hash_rd_en          (i_hash_rd_en),
        .i_hash_data_out       (i_hash_data_out),
        .i_hash_data_out_valid (i_hash_data_out_valid),
        .o_hash_data_out_ready (o_hash_data_out_ready),
        .o_hash_input_length   (o_hash_input_length),
        .o_hash_output_length  (o_hash_output_length),
        .o_hash_start          (o_hash_start),
        .i_hash_force_done_ack (i_hash_force_done_ack),
        .o_hash_force_done     (o_hash_force_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse counters sampled every cycle, read as deltas by the tests.
    int hs_total = 0;
    int done_total = 0;
    always @(negedge clk) begin
        if (o_hash_start) hs_total++;
        if (o_done) done_total++;
    end

    logic [31:0] h2_model [8];
    logic [31:0] sq_words [5];
    logic [7:0]  got [17];
    int          gap_max, mid_start, abort_after;
    int          absorb_bad, accepted, timeout;
    logic        ready_after, force_seen, done_now, done_after;

    // Mock XOF output for the all-zero h2 and the per-word byte expectations.
    localparam logic [31:0] ZERO_WORDS [5] = '{32'h01234567, 32'h12345678, 32'h23456789,
                                               32'h3456789A, 32'h456789AB};
    localparam logic [7:0]  ZERO_ISTAR [17] = '{8'h67, 8'h45, 8'h23, 8'h01, 8'h78, 8'h56,
                                                8'h34, 8'h12, 8'h89, 8'h67, 8'h45, 8'h23,
                                                8'h9A, 8'h78, 8'h56, 8'h34, 8'hAB};
    localparam logic [31:0] MOCK_WORDS [5] = '{32'h03020100, 32'h07060504, 32'h0B0A0908,
                                               32'h0F0E0D0C, 32'h000000FF};
    localparam logic [31:0] LOAD_WORDS [8] = '{32'h00010203, 32'h04050607, 32'h08090A0B,
                                               32'h0C0D0E0F, 32'h10111213, 32'h14151617,
                                               32'h18191A1B, 32'h1C1D1E1F};

    task automatic write_h2;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            i_h2_wr_en = 1'b1;
            i_h2_addr  = 3'(w);
            i_h2       = h2_model[w];
        end
        @(negedge clk);
        i_h2_wr_en = 1'b0;
    endtask

    task automatic read_istar;
        for (int k = 0; k < 17; k++) begin
            i_i_star_rd_en = 1'b1;
            i_i_star_addr  = 5'(k);
            @(negedge clk);
            got[k] = o_i_star;
        end
        i_i_star_rd_en = 1'b0;
    endtask

    // Drives one start..done operation as the XOF would; records observations only.
    task automatic run_op;
        int t;
        absorb_bad = 0;
        accepted   = 0;
        timeout    = 0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        t = 0;
        while (!o_hash_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!o_hash_start) timeout++;
        for (int w = 0; w < 8; w++) begin
            i_hash_rd_en = 1'b1;
            i_hash_addr  = 3'(w);
            @(negedge clk);
            if (o_hash_data_in !== h2_model[w]) absorb_bad++;
        end
        i_hash_rd_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == abort_after) begin
                i_rst = 1'b0;
                return;
            end
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            if (mid_start != 0 && k == 2) begin
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
            i_hash_data_out       = sq_words[k];
            i_hash_data_out_valid = 1'b1;
            t = 0;
            while (!o_hash_data_out_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (o_hash_data_out_ready) accepted++;
            else timeout++;
            @(negedge clk);
            i_hash_data_out_valid = 1'b0;
        end
        ready_after = o_hash_data_out_ready;
        t = 0;
        while (!o_hash_force_done && t < 20) begin
            @(negedge clk);
            t++;
        end
        force_seen = o_hash_force_done;
        i_hash_force_done_ack = 1'b1;
        @(negedge clk);
        i_hash_force_done_ack = 1'b0;
        done_now = o_done;
        @(negedge clk);
        done_after = o_done;
    endtask

    task automatic test_reset;
        i_rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp += 8;
        if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", o_done); end
        if (o_hash_start !== 1'b0) begin n_bad++; $display("FAIL reset_hash_start got %b want 0", o_hash_start); end
        if (o_hash_force_done !== 1'b0) begin n_bad++; $display("FAIL reset_force got %b want 0", o_hash_force_done); end
        if (o_hash_data_out_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", o_hash_data_out_ready); end
        if (o_h2 !== 32'h0) begin n_bad++; $display("FAIL reset_o_h2 got %h want 0", o_h2); end
        if (o_i_star !== 8'h0) begin n_bad++; $display("FAIL reset_o_i_star got %h want 0", o_i_star); end
        if (o_hash_input_length !== 32'd256) begin n_bad++; $display("FAIL in_len got %0d want 256", o_hash_input_length); end
        if (o_hash_output_length !== 32'd136) begin n_bad++; $display("FAIL out_len got %0d want 136", o_hash_output_length); end
        @(negedge clk);
        i_rst = 1'b1;
    endtask

    task automatic test_h2_load;
        for (int w = 0; w < 8; w++) h2_model[w] = LOAD_WORDS[w];
        write_h2();
        for (int w = 7; w >= 0; w--) begin
            i_h2_rd_en = 1'b1;
            i_h2_addr  = 3'(w);
            @(negedge clk);
            n_cmp++;
            if (o_h2 !== LOAD_WORDS[w]) begin
                n_bad++;
                $display("FAIL h2_readback[%0d] got %h want %h", w, o_h2, LOAD_WORDS[w]);
            end
        end
        i_h2_rd_en = 1'b0;
    endtask

    task automatic check_run(input string name, input int hs0, input int dn0);
        n_cmp += 8;
        if (timeout != 0) begin n_bad++; $display("FAIL %s timeout got %0d want 0", name, timeout); end
        if (hs_total - hs0 != 1) begin n_bad++; $display("FAIL %s hash_start_pulses got %0d want 1", name, hs_total - hs0); end
        if (absorb_bad != 0) begin n_bad++; $display("FAIL %s absorb_words got %0d bad want 0", name, absorb_bad); end
        if (accepted != 5) begin n_bad++; $display("FAIL %s accepted got %0d want 5", name, accepted); end
        if (ready_after !== 1'b0) begin n_bad++; $display("FAIL %s ready_after_last got %b want 0", name, ready_after); end
        if (force_seen !== 1'b1) begin n_bad++; $display("FAIL %s force_done got %b want 1", name, force_seen); end
        if (done_now !== 1'b1 || done_after !== 1'b0) begin
            n_bad++; $display("FAIL %s done_pulse got %b%b want 10", name, done_now, done_after);
        end
        if (done_total - dn0 != 1) begin n_bad++; $display("FAIL %s done_pulses got %0d want 1", name, done_total - dn0); end
    endtask

    task automatic test_zero_run;
        int hs0, dn0;
        for (int w = 0; w < 8; w++) h2_model[w] = 32'h0;
        write_h2();
        for (int k = 0; k < 5; k++) sq_words[k] = ZERO_WORDS[k];
        gap_max = 0; mid_start = 0; abort_after = 5;
        hs0 = hs_total; dn0 = done_total;
        run_op();
        repeat (2) @(negedge clk);
        check_run("zero_run", hs0, dn0);
        read_istar();
        for (int k = 0; k < 17; k++) begin
            n_cmp++;
            if (got[k] !== ZERO_ISTAR[k]) begin
                n_bad++; $display("FAIL zero_istar[%0d] got %h want %h", k, got[k], ZERO_ISTAR[k]);
            end
        end
    endtask

    task automatic test_mock_xof;
        int hs0, dn0;
        logic [7:0] want;
        for (int k = 0; k < 5; k++) sq_words[k] = MOCK_WORDS[k];
        gap_max = 3; mid_start = 0; abort_after = 5;
        hs0 = hs_total; dn0 = done_total;
        run_op();
        repeat (2) @(negedge clk);
        check_run("mock_xof", hs0, dn0);
        read_istar();
        for (int k = 0; k < 17; k++) begin
            want = (k == 16) ? 8'hFF : 8'(k);
            n_cmp++;
            if (got[k] !== want) begin
                n_bad++; $display("FAIL mock_istar[%0d] got %h want %h", k, got[k], want);
            end
        end
    endtask

    task automatic test_start_in_squeeze;
        int hs0, dn0;
        for (int k = 0; k < 5; k++) sq_words[k] = ZERO_WORDS[k];
        gap_max = 1; mid_start = 1; abort_after = 5;
        hs0 = hs_total; dn0 = done_total;
        run_op();
        repeat (4) @(negedge clk);
        check_run("start_in_squeeze", hs0, dn0);
        read_istar();
        for (int k = 0; k < 17; k++) begin
            n_cmp++;
            if (got[k] !== ZERO_ISTAR[k]) begin
                n_bad++; $display("FAIL start_in_squeeze_istar[%0d] got %h want %h", k, got[k], ZERO_ISTAR[k]);
            end
        end
    endtask

    task automatic test_reset_in_squeeze;
        int hs0, dn0;
        logic [7:0] want;
        for (int k = 0; k < 5; k++) sq_words[k] = ZERO_WORDS[k];
        gap_max = 0; mid_start = 0; abort_after = 2;
        dn0 = done_total;
        run_op();
        #1;
        n_cmp += 3;
        if (o_hash_force_done !== 1'b0) begin n_bad++; $display("FAIL abort_force got %b want 0", o_hash_force_done); end
        if (o_hash_data_out_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready got %b want 0", o_hash_data_out_ready); end
        if (o_hash_data_in !== 32'h0) begin n_bad++; $display("FAIL abort_data_in got %h want 0", o_hash_data_in); end
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done_total != dn0) begin n_bad++; $display("FAIL abort_stale_done got %0d want 0", done_total - dn0); end
        for (int k = 0; k < 5; k++) sq_words[k] = MOCK_WORDS[k];
        abort_after = 5; gap_max = 2;
        hs0 = hs_total; dn0 = done_total;
        run_op();
        repeat (2) @(negedge clk);
        check_run("restart", hs0, dn0);
        read_istar();
        for (int k = 0; k < 17; k++) begin
            want = (k == 16) ? 8'hFF : 8'(k);
            n_cmp++;
            if (got[k] !== want) begin
                n_bad++; $display("FAIL restart_istar[%0d] got %h want %h", k, got[k], want);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        gap_max = 0; mid_start = 0; abort_after = 5;
        test_reset();
        test_h2_load();
        test_zero_run();
        test_mock_xof();
        test_start_in_squeeze();
        test_reset_in_squeeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdith_expand_view_challenge.md
Name: sdith_expand_view_challenge

Overview:
- SDitH signing step that expands the second Fiat-Shamir hash h2 into TAU hidden-party indices i_star, one per parallel repetition.
- Holds h2 in a local 32-bit word RAM, which the host loads.
- Streams h2 into the shared XOF core (hash_mem_interface) and squeezes TAU bytes.
- Stores the bytes in an index buffer that downstream signing logic reads.

Parameters:
- PARAMETER_SET, "L1", selects L1/L3/L5.
- LAMBDA, 128/192/256 by set, security level in bits.
- SEED_SIZE, LAMBDA, h2 half-size; h2 is 2*SEED_SIZE bits.
- TAU, 17, number of repetitions, i.e. number of i_star entries.
- D_HYPERCUBE, 8, hypercube dimension; each index is D_HYPERCUBE bits (0..255).
- H2_WORDS, 2*SEED_SIZE/32, derived h2 depth in 32-bit words (L1 = 8).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle start pulse
- o_done  out  1  one-cycle completion pulse
- i_h2_wr_en  in  1  h2 RAM write enable
- i_h2_rd_en  in  1  h2 RAM host read enable
- i_h2_addr  in  clog2(H2_WORDS)  h2 word address
- i_h2  in  32  h2 write data
- o_h2  out  32  h2 read data
- i_i_star_rd_en  in  1  index read enable
- i_i_star_addr  in  clog2(TAU)  index address
- o_i_star  out  8  index read data
- o_hash_data_in  out  32  h2 word supplied to the XOF
- i_hash_addr  in  clog2(H2_WORDS)  XOF read address into h2
- i_hash_rd_en  in  1  XOF read enable
- i_hash_data_out  in  32  squeezed XOF word
- i_hash_data_out_valid  in  1  squeezed word valid
- o_hash_data_out_ready  out  1  ready for a squeezed word
- o_hash_input_length  out  32  absorb length in bits
- o_hash_output_length  out  32  squeeze length in bits
- o_hash_start  out  1  XOF start pulse
- i_hash_force_done_ack  in  1  XOF acknowledges forced stop
- o_hash_force_done  out  1  forced-stop request to the XOF

Behaviour:
- Reset (i_rst = 0, asynchronous):
  - FSM returns to IDLE.
  - All control outputs and counters clear to 0.
  - o_h2, o_i_star and o_hash_data_in clear to 0.
  - RAM/buffer contents are not cleared.
- Constant outputs: o_hash_input_length = 2*LAMBDA (256 for L1); o_hash_output_length = TAU*8 (136).
- h2 RAM:
  - H2_WORDS x 32, one port.
  - A write has priority over reads at the same address.
  - Reads are registered, 1-cycle latency.
  - o_hash_data_in = word at i_hash_addr, one cycle after i_hash_rd_en.
  - o_h2 = word at i_h2_addr, one cycle after i_h2_rd_en.
  - Absorb order is word 0 first; there is no domain-separation prefix.
- i_star buffer:
  - TAU x 8 flops.
  - o_i_star is registered, 1-cycle latency after i_i_star_rd_en.
- FSM states:
  - IDLE: i_start -> START.
  - START: o_hash_start = 1 for exactly one cycle -> SQUEEZE.
  - SQUEEZE:
    - o_hash_data_out_ready = 1.
    - On each valid cycle, byte j of the word (bits 8j+7:8j, j = 0..3, little-endian) goes to i_star[cnt+j] if cnt+j < TAU; cnt += 4.
    - The final word is partial for TAU = 17: only byte 0 is used.
    - When cnt >= TAU -> FORCE; ready drops in the same cycle the last needed word is accepted.
  - FORCE: hold o_hash_force_done = 1 until i_hash_force_done_ack -> DONE.
  - DONE: o_done = 1 for one cycle -> IDLE.
- Index values:
  - Each index is the raw byte, 0..255, with no rejection, since D_HYPERCUBE = 8 gives exactly 256 parties.
  - Wider D_HYPERCUBE is unsupported; elaboration fails if D_HYPERCUBE != 8.
- i_start outside IDLE is ignored.
- Valid gaps in SQUEEZE are tolerated (no timeout).
- Host h2 writes or i_star reads while busy are permitted but return undefined data.
- Reset mid-operation aborts immediately. o_hash_force_done deasserts; the XOF is reset by the same i_rst.
- Latency excluding XOF time: 1 (START) + ceil(TAU/4) accepted words + FORCE handshake + 1 (DONE).

Decomposition:
- Package sdith_pkg holds:
  - the per-set LAMBDA/TAU/K/T/D_SPLIT selection functions;
  - the D_HYPERCUBE constant;
  - the CLOG2 macro;
  - the hash-length constants.
- One natural sub-module: sdith_word_ram, a single-port synchronous RAM used for h2.
- The XOF core is external, hash_mem_interface, instantiated by the parent/bench.

Test Plan:
- Reset: hold i_rst = 0 for 10 cycles -> o_done, o_hash_start, o_hash_force_done and o_hash_data_out_ready are all 0; length outputs are 256 and 136 (L1).
- h2 load/readback: write words 0..7 = 0x00010203 + 0x04040404*i, then read -> o_h2 matches one cycle after each rd_en.
- Full run with h2 all-zero:
  - pulse i_start -> exactly one o_hash_start;
  - 5 squeezed words are accepted;
  - force_done handshake completes;
  - one o_done pulse;
  - i_star[0..16] equals the first 17 bytes of the golden XOF model, little-endian per word.
- Mock-XOF run: feed words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, 0x000000FF with random valid gaps -> i_star[k] = k for k = 0..15, i_star[16] = 0xFF; ready is low after the 5th word.
- i_start asserted during SQUEEZE -> no second o_hash_start; the result is unchanged.
- Reset asserted during SQUEEZE, then a new start -> clean restart and correct final i_star; no stale o_done.
